// File: rtl/aquila_clint.sv
// ---------------------------------------------------------------------------
// aquila_clint
//   Core-local interruptor: 64-bit mtime counter with prescaler, 64-bit
//   mtimecmp compare register and a machine software interrupt bit (msip),
//   all reachable through a simple request/ready data bus in a 64 KiB window.
//
// Ports
//   clk_i               clock
//   rst_ni              asynchronous active-low reset
//   data_req_i          access request, held high by the master until ready
//   data_addr_i         byte address (bits [1:0] ignored)
//   data_rw_i           0 = read, 1 = write
//   data_byte_enable_i  write byte lanes
//   data_i              write data
//   data_o              read data, zero whenever data_ready_o is low
//   data_ready_o        one-cycle completion pulse, one cycle after acceptance
//   tmr_irq_o           registered (mtime >= mtimecmp)
//   sft_irq_o           msip bit 0
//
// Handshake
//   A request is accepted on a rising clk_i edge where data_req_i is high and
//   no response is outstanding. data_ready_o is high for exactly the following
//   cycle; during that cycle nothing is accepted even if data_req_i is still
//   high, so a master that drops data_req_i after seeing data_ready_o gets a
//   single completion. With a fixed latency of one, data_ready_o itself is the
//   "response pending" flag.
// ---------------------------------------------------------------------------
module aquila_clint #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              data_req_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic              data_rw_i,
    input  logic [XLEN/8-1:0] data_byte_enable_i,
    input  logic [XLEN-1:0]   data_i,
    output logic [XLEN-1:0]   data_o,
    output logic              data_ready_o,
    output logic              tmr_irq_o,
    output logic              sft_irq_o
);

    // Word indices (offset[15:2]) of the mapped registers
    localparam logic [13:0] IDX_MSIP   = 14'h0000;  // 0x0000
    localparam logic [13:0] IDX_CMP_LO = 14'h1000;  // 0x4000
    localparam logic [13:0] IDX_CMP_HI = 14'h1001;  // 0x4004
    localparam logic [13:0] IDX_MT_LO  = 14'h2FFE;  // 0xBFF8
    localparam logic [13:0] IDX_MT_HI  = 14'h2FFF;  // 0xBFFC

    localparam logic [32:0] WIN_LO     = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI     = WIN_LO + 33'h0_FFFF;
    localparam logic [15:0] PRESC_MAX  = 16'(TICK_DIV - 1);

    logic [63:0]     mtime;
    logic [63:0]     mtimecmp;
    logic            msip;
    logic [15:0]     presc;
    logic            tick;

    logic            accept;
    logic            wr;
    logic            in_win;
    logic [XLEN-1:0] offset;
    logic [13:0]     idx;
    logic            sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;
    logic [31:0]     rdata;
    logic            unused_offset_bits;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // ---------------- address decode ----------------
    assign accept = data_req_i && !data_ready_o;
    assign wr     = accept && data_rw_i;
    assign in_win = ({1'b0, data_addr_i} >= WIN_LO) && ({1'b0, data_addr_i} <= WIN_HI);
    assign offset = data_addr_i - BASE_ADDR;
    assign idx    = offset[15:2];
    assign unused_offset_bits = ^{offset[XLEN-1:16], offset[1:0]};

    assign sel_msip   = in_win && (idx == IDX_MSIP);
    assign sel_cmp_lo = in_win && (idx == IDX_CMP_LO);
    assign sel_cmp_hi = in_win && (idx == IDX_CMP_HI);
    assign sel_mt_lo  = in_win && (idx == IDX_MT_LO);
    assign sel_mt_hi  = in_win && (idx == IDX_MT_HI);

    // Read mux sees the pre-write register values of this cycle.
    always_comb begin
        rdata = '0;
        if (sel_msip)   rdata = {31'b0, msip};
        if (sel_cmp_lo) rdata = mtimecmp[31:0];
        if (sel_cmp_hi) rdata = mtimecmp[63:32];
        if (sel_mt_lo)  rdata = mtime[31:0];
        if (sel_mt_hi)  rdata = mtime[63:32];
    end

    // ---------------- prescaler ----------------
    assign tick = (presc == PRESC_MAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 16'd1;
    end

    // ---------------- mtime ----------------
    // A bus write to either half wins over the tick: the written half takes
    // the merged bytes and the other half holds, so no carry crosses halves
    // in that cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime <= '0;
        end else if (wr && sel_mt_lo) begin
            mtime[31:0] <= byte_merge(mtime[31:0], data_i, data_byte_enable_i);
        end else if (wr && sel_mt_hi) begin
            mtime[63:32] <= byte_merge(mtime[63:32], data_i, data_byte_enable_i);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // ---------------- mtimecmp / msip ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else begin
            if (wr && sel_cmp_lo)
                mtimecmp[31:0] <= byte_merge(mtimecmp[31:0], data_i, data_byte_enable_i);
            if (wr && sel_cmp_hi)
                mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], data_i, data_byte_enable_i);
            if (wr && sel_msip && data_byte_enable_i[0])
                msip <= data_i[0];
        end
    end

    // ---------------- interrupts ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tmr_irq_o <= 1'b0;
        else         tmr_irq_o <= (mtime >= mtimecmp);
    end

    assign sft_irq_o = msip;

    // ---------------- response ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_ready_o <= 1'b0;
            data_o       <= '0;
        end else begin
            data_ready_o <= accept;
            data_o       <= (accept && !data_rw_i) ? rdata : '0;
        end
    end

endmodule

// File: tb/tb_aquila_clint.sv
// ---------------------------------------------------------------------------
// tb_aquila_clint
//   Two instances share one bus: dut1 (TICK_DIV=1) is fully exercised, dut4
//   (TICK_DIV=4) is read-only to check the prescaler. The reference model
//   describes mtime as "value last written plus elapsed ticks" and holds the
//   other registers as plain variables, updated when a write is accepted.
// ---------------------------------------------------------------------------
module tb_aquila_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam logic [31:0] A_MSIP   = BASE + 32'h0000;
    localparam logic [31:0] A_CMP_LO = BASE + 32'h4000;
    localparam logic [31:0] A_CMP_HI = BASE + 32'h4004;
    localparam logic [31:0] A_MT_LO  = BASE + 32'hBFF8;
    localparam logic [31:0] A_MT_HI  = BASE + 32'hBFFC;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // edges = number of rising clock edges since reset release
    int edges;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    // ---------------- DUTs ----------------
    logic        req1, req4, rw;
    logic [31:0] addr, wd;
    logic [3:0]  be;
    logic [31:0] d1_o, d4_o;
    logic        rdy1, rdy4, tmr1, tmr4, sft1, sft4;

    aquila_clint #(.XLEN(32), .BASE_ADDR(BASE), .TICK_DIV(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req1), .data_addr_i(addr),
        .data_rw_i(rw), .data_byte_enable_i(be), .data_i(wd), .data_o(d1_o),
        .data_ready_o(rdy1), .tmr_irq_o(tmr1), .sft_irq_o(sft1));

    aquila_clint #(.XLEN(32), .BASE_ADDR(BASE), .TICK_DIV(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req4), .data_addr_i(addr),
        .data_rw_i(rw), .data_byte_enable_i(be), .data_i(wd), .data_o(d4_o),
        .data_ready_o(rdy4), .tmr_irq_o(tmr4), .sft_irq_o(sft4));

    // ---------------- reference model ----------------
    logic [63:0] mt_base;    // mtime value right after edge mt_edge
    int          mt_edge;
    logic [63:0] cmp_m;
    logic        msip_m;

    int compared   = 0;
    int mismatched = 0;

    function automatic logic [63:0] mt_at(input int e);
        return mt_base + 64'(e - mt_edge);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'h0000_FFFF);
    endfunction

    // Expected read value of the register at address a, as seen after edge e
    function automatic logic [31:0] exp_read(input bit d4, input logic [31:0] a, input int e);
        logic [31:0] woff;
        logic [63:0] mt;
        logic [63:0] cmp;
        if (!in_window(a)) return 32'h0;
        woff = (a - BASE) & 32'h0000_FFFC;
        mt   = d4 ? 64'(e / 4) : mt_at(e);
        cmp  = d4 ? 64'hFFFF_FFFF_FFFF_FFFF : cmp_m;
        case (woff)
            32'h0000: return {31'b0, d4 ? 1'b0 : msip_m};
            32'h4000: return cmp[31:0];
            32'h4004: return cmp[63:32];
            32'hBFF8: return mt[31:0];
            32'hBFFC: return mt[63:32];
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        mt_base = 64'h0;
        mt_edge = 0;
        cmp_m   = 64'hFFFF_FFFF_FFFF_FFFF;
        msip_m  = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One complete bus access on dut1 (d4=0) or dut4 (d4=1). The request is
    // held through the ready cycle and dropped afterwards.
    task automatic access(input bit d4, input logic [31:0] a, input bit w,
                          input logic [3:0] b, input logic [31:0] d);
        int          acc;
        logic [31:0] woff;
        logic [63:0] old;
        @(negedge clk);
        addr = a; rw = w; be = b; wd = d;
        if (d4) req4 = 1'b1; else req1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc = edges;
        check("ready_latency", d4 ? rdy4 : rdy1, 1'b1);
        if (!w) check("rdata", d4 ? d4_o : d1_o, exp_read(d4, a, acc - 1));
        if (w && !d4 && in_window(a)) begin
            woff = (a - BASE) & 32'h0000_FFFC;
            old  = mt_at(acc - 1);
            case (woff)
                32'h0000: if (b[0]) msip_m = d[0];
                32'h4000: cmp_m[31:0]  = merge(cmp_m[31:0], d, b);
                32'h4004: cmp_m[63:32] = merge(cmp_m[63:32], d, b);
                32'hBFF8: begin mt_base = {old[63:32], merge(old[31:0], d, b)}; mt_edge = acc; end
                32'hBFFC: begin mt_base = {merge(old[63:32], d, b), old[31:0]}; mt_edge = acc; end
                default: ;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0; req4 = 1'b0;
        check("ready_single", d4 ? rdy4 : rdy1, 1'b0);
        check("rdata_idle", d4 ? d4_o : d1_o, 32'h0);
        if (!d4) begin
            check("tmr_irq", tmr1, mt_at(edges - 1) >= cmp_m);
            check("sft_irq", sft1, msip_m);
        end else begin
            check("tmr_irq4", tmr4, 64'((edges - 1) / 4) >= 64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy1"}, rdy1, 1'b0);
        check({tag, "_d1"},   d1_o, 32'h0);
        check({tag, "_tmr1"}, tmr1, 1'b0);
        check({tag, "_sft1"}, sft1, 1'b0);
        check({tag, "_rdy4"}, rdy4, 1'b0);
        check({tag, "_d4"},   d4_o, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req1 = 1'b0; req4 = 1'b0;
        #2;
        check_all_zero("reset_async");
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] reg_addr[6];
    logic [63:0] tmp;
    int          op;

    initial begin
        req1 = 1'b0; req4 = 1'b0; rw = 1'b0; addr = '0; wd = '0; be = '0;
        reg_addr[0] = A_MSIP;   reg_addr[1] = A_CMP_LO; reg_addr[2] = A_CMP_HI;
        reg_addr[3] = A_MT_LO;  reg_addr[4] = A_MT_HI;  reg_addr[5] = BASE + 32'h1234;
        model_reset();

        // Reset state and first read of mtime ten cycles after release
        do_reset();
        repeat (10) @(negedge clk);
        access(0, A_MT_LO, 0, 4'hF, 0);
        access(0, A_MT_HI, 0, 4'hF, 0);
        access(0, A_CMP_LO, 0, 4'hF, 0);
        access(0, A_CMP_HI | 32'h3, 0, 4'hF, 0);

        // Prescaler: dut4 advances once per four cycles
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            access(1, A_MT_LO, 0, 4'hF, 0);
        end

        // Timer interrupt rises one cycle after mtime reaches mtimecmp
        do_reset();
        access(0, A_CMP_HI, 1, 4'hF, 32'h0);
        access(0, A_CMP_LO, 1, 4'hF, 32'd20);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("irq_rise", tmr1, mt_at(edges - 1) >= cmp_m);
        end
        access(0, A_CMP_LO, 1, 4'hF, 32'hFFFF_FFFF);   // clears next cycle
        check("irq_cleared", tmr1, 1'b0);

        // Byte lanes on msip
        access(0, A_MSIP, 1, 4'h2, 32'h0000_0001);
        check("sft_lane1", sft1, 1'b0);
        access(0, A_MSIP, 1, 4'h1, 32'h0000_0001);
        check("sft_lane0", sft1, 1'b1);
        access(0, A_MSIP, 0, 4'hF, 0);
        access(0, A_MSIP | 32'h2, 0, 4'hF, 0);

        // Unmapped and out-of-window accesses
        access(0, BASE + 32'h1234, 1, 4'hF, 32'hFFFF_FFFF);
        access(0, BASE + 32'h1234, 0, 4'hF, 0);
        access(0, BASE + 32'h1_0000, 0, 4'hF, 0);
        access(0, BASE - 32'h4, 0, 4'hF, 0);
        access(0, BASE + 32'h1_4000, 1, 4'hF, 32'h0);   // aliased offset outside window
        access(0, A_CMP_LO, 0, 4'hF, 0);

        // Wrap of the full 64-bit counter
        access(0, A_MT_HI, 1, 4'hF, 32'hFFFF_FFFF);
        access(0, A_MT_LO, 1, 4'hF, 32'hFFFF_FFFE);
        access(0, A_MT_LO, 0, 4'hF, 0);
        tmp = mt_at(edges);
        check("wrapped_small", 64'(tmp < 64'd16), 64'd1);
        access(0, A_MT_HI, 0, 4'hF, 0);

        // Write collisions with the tick, including a partial lane write
        access(0, A_MT_LO, 1, 4'hF, 32'hFFFF_FFF0);
        access(0, A_MT_LO, 1, 4'hF, 32'd5);
        access(0, A_MT_LO, 0, 4'hF, 0);
        access(0, A_MT_HI, 0, 4'hF, 0);
        access(0, A_MT_LO, 1, 4'h1, 32'hAAAA_AA00);
        access(0, A_MT_LO, 0, 4'hF, 0);

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 7);
            case (op)
                0: access(0, reg_addr[$urandom_range(0, 5)] | 32'($urandom_range(0, 3)), 0, 4'hF, 0);
                1: access(0, A_MSIP, 1, 4'($urandom_range(0, 15)), $urandom);
                2: access(0, A_CMP_LO, 1, 4'($urandom_range(0, 15)), $urandom);
                3: begin
                       tmp = mt_at(edges);
                       access(0, A_CMP_HI, 1, 4'hF, ($urandom_range(0, 1) != 0) ? tmp[63:32] : $urandom);
                   end
                4: access(0, A_MT_LO, 1, 4'($urandom_range(0, 15)), $urandom);
                5: access(0, A_MT_HI, 1, 4'($urandom_range(0, 15)), 32'($urandom_range(0, 3)));
                6: access(1, ($urandom_range(0, 1) != 0) ? A_MT_LO : A_MT_HI, 0, 4'hF, 0);
                default: repeat ($urandom_range(1, 3)) @(negedge clk);
            endcase
        end

        // Reset asserted while a request is on the bus
        access(0, A_MSIP, 1, 4'h1, 32'h1);
        @(negedge clk);
        addr = A_CMP_LO; rw = 1'b0; be = 4'hF; req1 = 1'b1; req4 = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        repeat (2) begin
            @(negedge clk);
            check("mid_reset_no_ready", rdy1, 1'b0);
        end
        req1 = 1'b0; req4 = 1'b0;
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_no_ready", rdy1, 1'b0);
        check("post_reset_no_ready4", rdy4, 1'b0);
        access(0, A_CMP_LO, 0, 4'hF, 0);
        access(0, A_CMP_HI, 0, 4'hF, 0);
        access(0, A_MT_LO, 0, 4'hF, 0);
        access(1, A_MT_LO, 0, 4'hF, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
